// File: rtl/fp16_convert_arbiter.sv
// Round-robin sharing of one uint8.12->fp16 converter between NUM_REQ requesters,
// with credit-based issue into an output FIFO. Define FP16_ARB_STATS_EN for issue/stall counters.

module uint8_12_to_fp16_converter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [19:0] data_i,
  output logic        valid_o,
  output logic [15:0] fp16_o
);
  logic [4:0]  w_pos;
  logic        w_nz;
  logic [19:0] w_shift;
  logic [15:0] w_fp;

  // Leading-one position sets the exponent (bias 15, binary point at bit 12 -> pos+3).
  always_comb begin
    w_pos = '0;
    w_nz  = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (data_i[i]) begin
        w_pos = 5'(i);
        w_nz  = 1'b1;
      end
    end
    w_shift = data_i << (5'd19 - w_pos);
    w_fp    = w_nz ? {1'b0, w_pos + 5'd3, 10'(w_shift >> 9)} : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_o <= 1'b0;
    else       valid_o <= valid_i;
    fp16_o <= w_fp;
  end
endmodule

module fp16_convert_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ*20-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [15:0]           fp16_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef FP16_ARB_STATS_EN
  ,
  output logic [31:0]           issue_count_o,
  output logic [31:0]           credit_stall_count_o
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ID_WIDTH-1:0] r_rr_ptr, r_id_pipe, w_gnt_idx;
  logic [ID_WIDTH:0]   w_cand;
  logic                w_gnt_found, w_credit, w_xfer;
  logic [19:0]         w_sel_data;
  logic                w_conv_valid;
  logic [15:0]         w_conv_fp16;

  logic [ID_WIDTH+15:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic                 w_push, w_pop;

  // The converter's valid output is exactly the "accepted last cycle" in-flight flag.
  assign w_credit = (32'(r_count) + 32'(w_conv_valid)) < 32'(FIFO_DEPTH);

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(i);
      if (w_cand >= (ID_WIDTH+1)'(NUM_REQ)) w_cand = w_cand - (ID_WIDTH+1)'(NUM_REQ);
      if (!w_gnt_found && req_valid_i[ID_WIDTH'(w_cand)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_WIDTH'(w_cand);
      end
    end
    w_xfer      = w_gnt_found && w_credit && !rst_i;
    req_ready_o = '0;
    if (w_xfer) req_ready_o[w_gnt_idx] = 1'b1;
    w_sel_data  = req_data_i[32'(w_gnt_idx)*20 +: 20];
  end

  uint8_12_to_fp16_converter u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (w_xfer),
    .data_i  (w_sel_data),
    .valid_o (w_conv_valid),
    .fp16_o  (w_conv_fp16)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
    if (w_xfer) r_id_pipe <= w_gnt_idx;
  end

  assign valid_o = (r_count != '0);
  assign w_push  = w_conv_valid;
  assign w_pop   = valid_o && ready_i;
  assign {id_o, fp16_o} = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= {r_id_pipe, w_conv_fp16};
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FP16_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_count_o        <= '0;
      credit_stall_count_o <= '0;
    end else begin
      if (w_xfer) issue_count_o <= issue_count_o + 1'b1;
      if ((|req_valid_i) && !w_credit) credit_stall_count_o <= credit_stall_count_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fp16_convert_arbiter.sv
// Scoreboard bench for fp16_convert_arbiter: transfers push expected {id, fp16},
// a negedge monitor pops and compares each FIFO output.
module tb_fp16_convert_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*20-1:0] req_data;
  logic [NR-1:0]   req_valid, req_ready;
  logic [15:0]     fp16;
  logic [1:0]      id;
  logic            valid, ready;
`ifdef FP16_ARB_STATS_EN
  logic [31:0]     issue_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  fp16_convert_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .fp16_o      (fp16),
    .id_o        (id),
    .valid_o     (valid),
    .ready_i     (ready)
`ifdef FP16_ARB_STATS_EN
    ,
    .issue_count_o        (issue_cnt),
    .credit_stall_count_o (stall_cnt)
`endif
  );

  logic [15:0] exp_fp [NR];
  logic [17:0] sb_q [$];
  int          n_cmp = 0, n_fail = 0, n_xfer = 0;
  logic        had_hold = 1'b0;
  logic [17:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      had_hold = 1'b0;
    end else begin
      if (had_hold) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", 32'({id, fp16}), 32'(held));
      end
      if (valid && ready) begin
        if (sb_q.size() == 0) check("unexpected_output", 32'({id, fp16}), 32'hFFFF_FFFF);
        else check("scoreboard", 32'({id, fp16}), 32'(sb_q.pop_front()));
      end
      had_hold = valid && !ready;
      held     = {id, fp16};
      for (int k = 0; k < NR; k++)
        if (req_valid[k] && req_ready[k]) begin
          sb_q.push_back({2'(k), exp_fp[k]});
          n_xfer++;
        end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input int k, input logic [19:0] d, input logic [15:0] e);
    req_data[k*20 +: 20] = d;
    exp_fp[k] = e;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0 && !valid) break;
      tick();
    end
    check("drain_empty", {30'd0, sb_q.size() == 0, !valid}, 32'd3);
  endtask

  task automatic single(input int k, input logic [19:0] d, input logic [15:0] e);
    drive(k, d, e);
    req_valid = 4'(32'd1 << k);
    @(negedge clk); check("single_grant", 32'(req_ready), 32'd1 << k);
    tick();
    req_valid = '0;
    @(negedge clk); check("lat_t1_valid", 32'(valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_t2_valid", 32'(valid), 32'd1);
    check("lat_t2_fp16", 32'(fp16), 32'(e));
    check("lat_t2_id", 32'(id), 32'(k));
    tick();
  endtask

  typedef struct { int k; logic [19:0] d; logic [15:0] e; } vec_t;
  vec_t singles [8] = '{
    '{2, 20'h01000, 16'h3C00}, '{2, 20'h00800, 16'h3800},
    '{2, 20'hFF000, 16'h5BF8}, '{2, 20'h00000, 16'h0000},
    '{0, 20'h12345, 16'h4C8D}, '{1, 20'h00001, 16'h0C00},
    '{3, 20'h01001, 16'h3C00}, '{3, 20'h64000, 16'h5640}
  };

  task automatic load_all;
    drive(0, 20'h01000, 16'h3C00);
    drive(1, 20'h03000, 16'h4200);
    drive(2, 20'h12345, 16'h4C8D);
    drive(3, 20'h00001, 16'h0C00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; req_valid = '0; ready = 1'b1; req_data = '0;
    for (int k = 0; k < NR; k++) exp_fp[k] = '0;
    repeat (2) tick();
    req_valid = '1;
    @(negedge clk); check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    @(negedge clk); check("rst_valid", 32'(valid), 32'd0);
    tick();

    for (int i = 0; i < 8; i++) single(singles[i].k, singles[i].d, singles[i].e);
    wait_drain();

    // Round-robin under continuous load
    do_reset();
    load_all();
    base = n_xfer;
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); check("rr_grant", 32'(req_ready), 32'd1 << (i % 4));
      tick();
    end
    req_valid = '0;
    wait_drain();
    check("rr_xfers", 32'(n_xfer - base), 32'd8);

    // Backpressure: 4 credits then stall for 10 cycles
    do_reset();
    ready = 1'b0;
    base = n_xfer;
    req_valid = '1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 13) check("bp_ready_blocked", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("bp_xfers", 32'(n_xfer - base), 32'd4);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_head", 32'({id, fp16}), 32'({2'd0, 16'h3C00}));
`ifdef FP16_ARB_STATS_EN
    check("stats_issue", issue_cnt, 32'd4);
    check("stats_stall", stall_cnt, 32'd10);
`endif
    repeat (3) tick();
    ready = 1'b1;
    wait_drain();

    // Sparse request and wrap of rr_ptr
    do_reset();
    drive(2, 20'h02800, 16'h4100);
    req_valid = 4'b0100;
    tick();
    drive(1, 20'h00C00, 16'h3A00);
    req_valid = 4'b0010;
    @(negedge clk); check("sparse_grant", 32'(req_ready), 32'b0010);
    tick();
    drive(0, 20'h0A000, 16'h4900);
    drive(2, 20'h00400, 16'h3400);
    req_valid = 4'b0101;
    @(negedge clk); check("wrap_grant", 32'(req_ready), 32'b0100);
    tick();
    @(negedge clk); check("wrap_next_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_drain();

    // Reset with 3 FIFO entries and one sample in flight
    do_reset();
    load_all();
    ready = 1'b0;
    req_valid = '1;
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk); check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; ready = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("mid_post_valid", 32'(valid), 32'd0);
    check("mid_post_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    @(negedge clk); check("mid_t1_valid", 32'(valid), 32'd0);
    tick();
    @(negedge clk);
    check("mid_t2_out", 32'({valid, id, fp16}), 32'({1'b1, 2'd1, 16'h4200}));
    tick();
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
